// File: rtl/graph_pkg.sv
// Shared definitions for the graph search block and its edge RAM producer:
// sizing, edge word layout, writer FSM encoding and the pose validity check.
package graph_pkg;

  localparam int N_POSE = 66;
  localparam int N_EDGE = 1034;
  localparam int ADDR_W = 11;
  localparam int POSE_W = 8;
  localparam int WORD_W = 2 * POSE_W;

  // Edge word layout: first pose in the upper byte, second pose in the lower byte.
  localparam int FIRST_MSB  = 15;
  localparam int FIRST_LSB  = 8;
  localparam int SECOND_MSB = 7;
  localparam int SECOND_LSB = 0;

  // Writer FSM state encoding.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } writer_state_e;

  // An edge is unusable when either pose is out of range or it is a self-loop.
  function automatic logic edge_bad(input logic [POSE_W-1:0] first,
                                    input logic [POSE_W-1:0] second);
    return (first >= POSE_W'(N_POSE)) | (second >= POSE_W'(N_POSE)) | (first == second);
  endfunction

  // Pack a pose pair into the edge RAM word.
  function automatic logic [WORD_W-1:0] edge_word(input logic [POSE_W-1:0] first,
                                                  input logic [POSE_W-1:0] second);
    logic [WORD_W-1:0] w;
    w = '0;
    w[FIRST_MSB:FIRST_LSB]   = first;
    w[SECOND_MSB:SECOND_LSB] = second;
    return w;
  endfunction

endpackage

// File: rtl/graph_edge_writer.sv
// Producer side of the graph edge RAM. Writes each accepted edge at the next
// consecutive address, builds the per-edge exclusion mask and raises done when
// the set is complete so the search engine can start.
//
// Handshake: an edge transfers on a rising CLK edge where inValid and inReady
// are both 1. inReady is registered and only depends on writer state, never on
// inValid. A start pulse in the same cycle wins and the offered edge is dropped.
module graph_edge_writer
  import graph_pkg::*;
(
  input  logic                CLK,
  input  logic                RST_n,
  input  logic                start,
  input  logic                inValid,
  output logic                inReady,
  input  logic [POSE_W-1:0]   inFirst,
  input  logic [POSE_W-1:0]   inSecond,
  input  logic                inCollide,
  input  logic                inLast,
  output logic                ramWe,
  output logic [ADDR_W-1:0]   ramWrAddress,
  output logic [WORD_W-1:0]   ramWrData,
  output logic [N_EDGE-1:0]   edgeMask,
  output logic [ADDR_W-1:0]   edgeCount,
  output logic                busy,
  output logic                done,
  output writer_state_e       dbg_state
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_EDGE - 1);

  writer_state_e       r_state;
  logic                r_in_ready;
  logic                r_ram_we;
  logic [ADDR_W-1:0]   r_ram_addr;
  logic [WORD_W-1:0]   r_ram_data;
  logic [N_EDGE-1:0]   r_edge_mask;
  logic [ADDR_W-1:0]   r_edge_count;
  logic                r_busy;
  logic                r_done;

  logic                w_hs;
  logic                w_term;
  logic                w_bad;

  assign w_hs   = inValid & r_in_ready;
  assign w_term = inLast | (r_edge_count == LAST_ADDR);
  assign w_bad  = edge_bad(inFirst, inSecond);

  // Writer FSM: load control, RAM write port, mask and count, all registered.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_state      <= ST_IDLE;
      r_in_ready   <= 1'b0;
      r_ram_we     <= 1'b0;
      r_ram_addr   <= '0;
      r_ram_data   <= '0;
      r_edge_mask  <= '1;
      r_edge_count <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_ram_we <= 1'b0;
      if (start) begin
        // Start from any state restarts the load; unwritten edges stay masked.
        r_state      <= ST_LOAD;
        r_in_ready   <= 1'b1;
        r_edge_mask  <= '1;
        r_edge_count <= '0;
        r_busy       <= 1'b1;
        r_done       <= 1'b0;
      end else if (r_state == ST_LOAD && w_hs) begin
        r_ram_we                  <= 1'b1;
        r_ram_addr                <= r_edge_count;
        r_ram_data                <= edge_word(inFirst, inSecond);
        r_edge_mask[r_edge_count] <= inCollide | w_bad;
        r_edge_count              <= r_edge_count + ADDR_W'(1);
        // The last RAM slot always terminates, so edgeCount < N_EDGE holds
        // for as long as inReady is 1 in LOAD.
        if (w_term) begin
          r_state    <= ST_DONE;
          r_in_ready <= 1'b0;
          r_busy     <= 1'b0;
          r_done     <= 1'b1;
        end
      end
    end
  end

  assign inReady      = r_in_ready;
  assign ramWe        = r_ram_we;
  assign ramWrAddress = r_ram_addr;
  assign ramWrData    = r_ram_data;
  assign edgeMask     = r_edge_mask;
  assign edgeCount    = r_edge_count;
  assign busy         = r_busy;
  assign done         = r_done;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_graph_edge_writer.sv
// Self-checking bench for graph_edge_writer: directed steps plus randomized
// streams checked against a transaction-level model of the edge load.
module tb_graph_edge_writer;
  import graph_pkg::*;

  localparam int NE = 1034;

  logic              CLK;
  logic              RST_n;
  logic              start;
  logic              inValid;
  logic              inReady;
  logic [7:0]        inFirst;
  logic [7:0]        inSecond;
  logic              inCollide;
  logic              inLast;
  logic              ramWe;
  logic [10:0]       ramWrAddress;
  logic [15:0]       ramWrData;
  logic [NE-1:0]     edgeMask;
  logic [10:0]       edgeCount;
  logic              busy;
  logic              done;
  writer_state_e     dbg_state;

  graph_edge_writer dut (
    .CLK(CLK), .RST_n(RST_n), .start(start), .inValid(inValid), .inReady(inReady),
    .inFirst(inFirst), .inSecond(inSecond), .inCollide(inCollide), .inLast(inLast),
    .ramWe(ramWe), .ramWrAddress(ramWrAddress), .ramWrData(ramWrData),
    .edgeMask(edgeMask), .edgeCount(edgeCount), .busy(busy), .done(done),
    .dbg_state(dbg_state)
  );

  // Clock and reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Reference model of one load, kept as plain counters and a mask image.
  bit            m_load;
  bit            m_done;
  bit            m_busy;
  int            m_count;
  logic [NE-1:0] m_mask;
  bit            exp_we;
  int            exp_addr;
  logic [15:0]   exp_data;
  int            hs_cnt;
  int            we_cnt;
  logic [15:0]   ram [0:2047];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_mask(input string tag, input logic [NE-1:0] obs, input logic [NE-1:0] exp);
    int ndiff;
    int first_bad;
    ndiff = 0;
    first_bad = -1;
    for (int i = 0; i < NE; i++) begin
      if (obs[i] !== exp[i]) begin
        ndiff++;
        if (first_bad < 0) first_bad = i;
      end
    end
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d differing bits (first at %0d, value %b) expected bit %b",
             tag, ndiff, first_bad, obs[first_bad], exp[first_bad]);
    end
  endtask

  function automatic bit model_bad(input int f, input int s);
    return (f >= 66) || (s >= 66) || (f == s);
  endfunction

  function automatic writer_state_e model_state();
    if (m_load) return ST_LOAD;
    if (m_done) return ST_DONE;
    return ST_IDLE;
  endfunction

  task automatic model_reset();
    m_load = 0; m_done = 0; m_busy = 0; m_count = 0; m_mask = '1; exp_we = 0;
  endtask

  // Scoreboard check of all outputs after a clock edge; records RAM writes.
  task automatic check_outputs(input string tag);
    chk({tag, "_ramWe"}, 64'(ramWe), 64'(exp_we));
    if (ramWe === 1'b1) begin
      we_cnt++;
      ram[ramWrAddress] = ramWrData;
    end
    if (exp_we) begin
      chk({tag, "_addr"}, 64'(ramWrAddress), 64'(exp_addr));
      chk({tag, "_data"}, 64'(ramWrData), 64'(exp_data));
    end
    chk({tag, "_busy"}, 64'(busy), 64'(m_busy));
    chk({tag, "_done"}, 64'(done), 64'(m_done));
    chk({tag, "_count"}, 64'(edgeCount), 64'(m_count));
    chk({tag, "_state"}, 64'(dbg_state), 64'(model_state()));
    chk_mask({tag, "_mask"}, edgeMask, m_mask);
  endtask

  // Driver: one clock cycle of stimulus, called at the falling edge.
  task automatic step(input string tag, input bit v, input int f, input int s,
                      input bit c, input bit l, input bit st);
    bit m_ready;
    bit hs;
    start = st; inValid = v; inFirst = f[7:0]; inSecond = s[7:0];
    inCollide = c; inLast = l;
    m_ready = m_load && (m_count < NE);
    chk({tag, "_inReady"}, 64'(inReady), 64'(m_ready));
    hs = v && m_ready && !st;
    exp_we = 0;
    if (st) begin
      m_load = 1; m_done = 0; m_busy = 1; m_count = 0; m_mask = '1;
    end else if (hs) begin
      hs_cnt++;
      exp_we = 1;
      exp_addr = m_count;
      exp_data = {f[7:0], s[7:0]};
      m_mask[m_count] = c | model_bad(f, s);
      m_count++;
      if (l || m_count == NE) begin
        m_load = 0; m_done = 1; m_busy = 0;
      end
    end
    @(posedge CLK);
    @(negedge CLK);
    check_outputs(tag);
  endtask

  task automatic idle(input string tag);
    step(tag, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int we0;
    int hs0;
    int fv;
    int sv;
    RST_n = 1'b0; start = 0; inValid = 0; inFirst = 0; inSecond = 0;
    inCollide = 0; inLast = 0;
    hs_cnt = 0; we_cnt = 0;
    model_reset();
    @(negedge CLK);
    @(negedge CLK);
    // Reset values
    chk("rst_inReady", 64'(inReady), 64'(0));
    chk("rst_addr", 64'(ramWrAddress), 64'(0));
    chk("rst_data", 64'(ramWrData), 64'(0));
    check_outputs("rst");
    RST_n = 1'b1;
    idle("idle0");

    // Test 1: basic three-edge load
    step("t1_start", 0, 0, 0, 0, 0, 1);
    step("t1_e0", 1, 1, 2, 0, 0, 0);
    step("t1_e1", 1, 2, 5, 1, 0, 0);
    step("t1_e2", 1, 5, 7, 0, 1, 0);
    idle("t1_idle");
    chk("t1_ram0", 64'(ram[0]), 64'h0102);
    chk("t1_ram1", 64'(ram[1]), 64'h0205);
    chk("t1_ram2", 64'(ram[2]), 64'h0507);
    chk("t1_mask_low", 64'(edgeMask[2:0]), 64'(3'b010));
    chk("t1_mask_high", 64'(&edgeMask[NE-1:3]), 64'(1));
    chk("t1_count", 64'(edgeCount), 64'(3));
    chk("t1_done", 64'(done), 64'(1));

    // Test 2: invalid pose pairs
    step("t2_start", 0, 0, 0, 0, 0, 1);
    step("t2_e0", 1, 3, 3, 0, 0, 0);
    step("t2_e1", 1, 70, 1, 0, 0, 0);
    step("t2_e2", 1, 4, 9, 0, 1, 0);
    chk("t2_mask", 64'(edgeMask[2:0]), 64'(3'b011));

    // Test 3: fill the whole RAM with inValid held high
    we0 = we_cnt;
    step("t3_start", 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < NE + 1; i++) begin
      fv = $urandom_range(0, 70);
      sv = $urandom_range(0, 70);
      step("t3_e", 1, fv, sv, $urandom_range(0, 1), 0, 0);
    end
    chk("t3_we_pulses", 64'(we_cnt - we0), 64'(NE));
    chk("t3_count", 64'(edgeCount), 64'(NE));
    chk("t3_done", 64'(done), 64'(1));
    chk("t3_inReady", 64'(inReady), 64'(0));

    // Test 4: random valid with ~30% idle cycles
    we0 = we_cnt;
    hs0 = hs_cnt;
    step("t4_start", 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 200; i++) begin
      step("t4_e", ($urandom_range(0, 9) >= 3), $urandom_range(0, 80), $urandom_range(0, 80),
           $urandom_range(0, 1), (i == 199), 0);
    end
    idle("t4_idle");
    chk("t4_we_vs_hs", 64'(we_cnt - we0), 64'(hs_cnt - hs0));

    // Test 5: restart mid-load, including start coincident with an offered edge
    step("t5_start", 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 10; i++) step("t5_a", 1, i, i + 1, 0, 0, 0);
    step("t5_restart", 1, 9, 8, 0, 0, 1);
    step("t5_b0", 1, 10, 11, 0, 0, 0);
    step("t5_b1", 1, 12, 13, 0, 1, 0);
    idle("t5_idle");
    chk("t5_count", 64'(edgeCount), 64'(2));
    chk("t5_mask_low", 64'(edgeMask[1:0]), 64'(2'b00));
    chk("t5_mask_high", 64'(&edgeMask[NE-1:2]), 64'(1));

    // Test 6: asynchronous reset mid-load, between clock edges
    step("t6_start", 0, 0, 0, 0, 0, 1);
    step("t6_e0", 1, 20, 21, 0, 0, 0);
    start = 0; inValid = 1; inFirst = 8'd22; inSecond = 8'd23; inCollide = 0; inLast = 0;
    @(posedge CLK);
    #2;
    RST_n = 1'b0;
    #1;
    model_reset();
    chk("t6_ramWe", 64'(ramWe), 64'(0));
    chk("t6_inReady", 64'(inReady), 64'(0));
    chk("t6_busy", 64'(busy), 64'(0));
    chk("t6_done", 64'(done), 64'(0));
    chk("t6_count", 64'(edgeCount), 64'(0));
    chk_mask("t6_mask", edgeMask, m_mask);
    @(negedge CLK);
    inValid = 0;
    RST_n = 1'b1;
    idle("t6_idle");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
